uart_frame_rx: RTL and testbench
================================

# uart_frame_rx

Receives an 8N1 UART byte stream on `sys_clk` and assembles fixed-length frames into a 160-bit word. It sits directly upstream of the debug capture stage: it produces `data_all[159:0]` and the `receive_end` strobe that the logic-analyzer probes sample. It also reports framing and timeout errors so a bench or probe can trigger on corrupt frames.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer division, truncated; ≥ 16 required)
- `FRAME_BYTES`, 20, bytes per frame; `data_all` width = 8*FRAME_BYTES
- `TIMEOUT_BITS`, 32, idle bit-periods before a partial frame is dropped (used only with `RX_TIMEOUT_EN`)
- `sys_clk`  in  1  system clock, all logic on rising edge
- `sys_rst`  in  1  asynchronous, active-high reset
- `rx`  in  1  UART line, asynchronous, idle high
- `data_all`  out  8*FRAME_BYTES  last complete frame; byte k at [8k+7:8k]; byte 0 is the first received
- `receive_end`  out  1  one-cycle pulse; `data_all` is new in the same cycle
- `frame_err`  out  1  one-cycle pulse on a bad stop bit or a timeout drop

## Operation
- `rx` passes through a 2-FF synchronizer (reset value 1). All decisions use the synchronized value.
- Byte FSM states:
  - IDLE: a falling edge enters START and clears the bit counter.
  - START: at `CLKS_PER_BIT/2`, sync rx = 0 enters DATA; rx = 1 (glitch) returns to IDLE with no error.
  - DATA: samples 8 bits LSB-first, one every `CLKS_PER_BIT` from the start-bit midpoint.
  - STOP: samples once; rx = 1 yields a valid byte; rx = 0 pulses `frame_err`, discards the byte, and resets the byte index to 0. Both cases return to IDLE at the stop midpoint, so a back-to-back start bit is caught.
- Frame assembly:
  - Each valid byte is written into a shadow register at index `byte_idx`, then `byte_idx` increments.
  - When `byte_idx` reaches FRAME_BYTES-1 and that byte is valid: the shadow plus the new byte is copied to `data_all`, `receive_end` pulses, and `byte_idx` wraps to 0.
  - `data_all` holds its value between frames. Partial frames never appear on it.
- Reset mid-byte or mid-frame: FSM → IDLE, `byte_idx` → 0, shadow and `data_all` → 0. No pulse is emitted.
- Reset values: `data_all` = 0, `receive_end` = 0, `frame_err` = 0.

## Timing
- Byte latency: valid-byte strobe 1 cycle after the stop-bit midpoint sample.
- `receive_end` asserts 1 cycle after the last byte's valid strobe, i.e. 2 cycles after the stop-bit midpoint, for exactly 1 cycle.
- Input-to-sample skew: 2 cycles (synchronizer).
- `receive_end` and `frame_err` are mutually exclusive in any cycle.
- A start edge within 1 cycle of the stop midpoint must not be lost.

## Configuration
- `RX_TIMEOUT_EN` defined:
  - A counter runs while in IDLE with `byte_idx` ≠ 0.
  - Once it reaches `TIMEOUT_BITS*CLKS_PER_BIT`: `byte_idx` → 0 and `frame_err` pulses once.
  - The counter clears on any start edge.
- Undefined: no timeout logic. A partial frame waits indefinitely for its remaining bytes.

## Structure
- Package `uart_rx_pkg`: the byte-FSM state enum (IDLE, START, DATA, STOP) and a `clks_per_bit` constant function.
- Sub-module `uart_byte_rx`:
  - Contains the synchronizer, byte FSM, and baud counter.
  - Outputs `byte_data[7:0]`, `byte_valid`, `byte_err`.
- The top level holds frame assembly and timeout logic.

## Test plan
All scenarios use the defaults (`CLKS_PER_BIT` = 434).
- Send bytes 0x00..0x13 back-to-back → one `receive_end` pulse; `data_all[7:0]` = 0x00, `data_all[159:152]` = 0x13; `frame_err` never asserted.
- Send 0xA5 with a stop bit of 0 as byte 5, then 20 good bytes of 0x5A → one `frame_err` pulse, then `receive_end` with all 20 bytes = 0x5A.
- Drive a 100-cycle low glitch on idle `rx` → no byte strobe, no error, FSM back in IDLE.
- Assert `sys_rst` during bit 4 of byte 10, then send 20 bytes of 0x3C → outputs 0 during reset; then one `receive_end` with `data_all` all 0x3C.
- With `RX_TIMEOUT_EN`: send 7 bytes, then idle for 40 bit-periods → one `frame_err` pulse; the next 20 bytes form a complete frame.
- Send two frames with zero idle between stop and start → two `receive_end` pulses, 200×434 cycles apart (±2 cycles).

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART frame receiver.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Whole system clocks per UART bit (truncated).
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: rx synchronizer, baud counter and byte FSM.
// Emits a one-cycle byte_valid_o or byte_err_o one cycle after the stop sample.
module uart_byte_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_data_o,
  output logic       byte_valid_o,
  output logic       byte_err_o,
  output logic       idle_o,
  output logic       start_o
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          fell;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          valid_q, err_q;
  logic          tick, byte_done;

  // Two-flop synchronizer plus one delay flop for falling-edge detect; line idles high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fell = rx_prev_q & ~rx_sync_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: half a bit to the start midpoint, then a full bit per sample.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fell) state_d = START;
      START: if (tick) state_d = rx_sync_q ? IDLE : DATA;
      DATA:  if (tick && bit_q == 3'd7) state_d = STOP;
      STOP:  if (tick) state_d = fell ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample strobes derived from state and baud counter.
  always_comb begin
    tick      = 1'b0;
    byte_done = 1'b0;
    unique case (state_q)
      START:     tick = (cnt_q == CW'(HALF - 1));
      DATA, STOP: tick = (cnt_q == CW'(CLKS_PER_BIT - 1));
      default:   tick = 1'b0;
    endcase
    byte_done = (state_q == STOP) && tick;
  end

  // Baud counter, shift register and registered byte strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
      valid_q <= byte_done &  rx_sync_q;
      err_q   <= byte_done & ~rx_sync_q;
      if (state_q == START && tick) bit_q <= '0;
      if (state_q == DATA && tick) begin
        shift_q <= {rx_sync_q, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end
    end
  end

  assign byte_data_o  = shift_q;
  assign byte_valid_o = valid_q;
  assign byte_err_o   = err_q;
  assign idle_o       = (state_q == IDLE);
  assign start_o      = (state_q == IDLE) & fell;

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: collects FRAME_BYTES good bytes into data_all.
// Optional idle timeout that drops a partial frame: build with RX_TIMEOUT_EN.
module uart_frame_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned FRAME_BYTES  = 20,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     rx,
  output logic [8*FRAME_BYTES-1:0] data_all,
  output logic                     receive_end,
  output logic                     frame_err
);

  localparam int unsigned CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int          IW   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int unsigned LAST = FRAME_BYTES - 1;

  logic [7:0] byte_data;
  logic       byte_valid, byte_err, idle, start;
  logic       to_fire;

  logic [FRAME_BYTES-1:0][7:0] shadow_q, frame_d, data_all_q;
  logic [IW-1:0]               byte_idx_q;
  logic                        receive_end_q, frame_err_q;
  logic                        last_byte;

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) u_byte (
    .clk_i        (sys_clk),
    .rst_i        (sys_rst),
    .rx_i         (rx),
    .byte_data_o  (byte_data),
    .byte_valid_o (byte_valid),
    .byte_err_o   (byte_err),
    .idle_o       (idle),
    .start_o      (start)
  );

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CPB;
  logic [31:0] to_cnt_q;
  logic        to_run;

  assign to_run  = idle && (byte_idx_q != '0);
  // Byte events win over a coinciding timeout so pulses stay exclusive.
  assign to_fire = to_run && (to_cnt_q == 32'(TO_LIMIT - 1)) && !byte_valid && !byte_err;

  // Idle counter for a stalled partial frame; any start edge restarts it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                          to_cnt_q <= '0;
    else if (start || !to_run || to_fire) to_cnt_q <= '0;
    else                                  to_cnt_q <= to_cnt_q + 32'd1;
  end
`else
  logic unused_timeout;
  assign to_fire        = 1'b0;
  assign unused_timeout = ^{idle, start, TIMEOUT_BITS[0]};
`endif

  assign last_byte = (byte_idx_q == IW'(LAST));

  // Completed frame: shadow with the final byte patched in.
  always_comb begin
    frame_d       = shadow_q;
    frame_d[LAST] = byte_data;
  end

  // Frame assembly; data_all only changes when a whole frame has arrived.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shadow_q      <= '0;
      data_all_q    <= '0;
      byte_idx_q    <= '0;
      receive_end_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      receive_end_q <= byte_valid & last_byte;
      frame_err_q   <= byte_err | to_fire;
      if (byte_err || to_fire) begin
        byte_idx_q <= '0;
      end else if (byte_valid) begin
        shadow_q[byte_idx_q] <= byte_data;
        if (last_byte) begin
          data_all_q <= frame_d;
          byte_idx_q <= '0;
        end else begin
          byte_idx_q <= byte_idx_q + 1'b1;
        end
      end
    end
  end

  assign data_all    = data_all_q;
  assign receive_end = receive_end_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx with a byte-level reference model.
module tb_uart_frame_rx;

  localparam int CPB = 16;   // 1.6 MHz / 100 kbaud
  localparam int FB  = 20;
  localparam int W   = 8 * FB;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         rx;
  logic [W-1:0] data_all;
  logic         receive_end, frame_err;

  uart_frame_rx #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .FRAME_BYTES(FB), .TIMEOUT_BITS(32)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx),
    .data_all(data_all), .receive_end(receive_end), .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int           ntests = 0, nfail = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   part_q[$];
  logic [W-1:0] last_exp = '0;
  int           exp_err = 0, seen_err = 0;
  int           re_cyc[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: frames are the consecutive good bytes since the last drop.
  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [W-1:0] f;
    if (!good) begin
      part_q.delete();
      exp_err++;
    end else begin
      part_q.push_back(b);
      if (part_q.size() == FB) begin
        f = '0;
        for (int i = 0; i < FB; i++) f[8*i +: 8] = part_q[i];
        exp_q.push_back(f);
        last_exp = f;
        part_q.delete();
      end
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Drives one 8N1 byte; model updated before the stop bit so the
  // expectation is queued before the DUT can produce it.
  task automatic send_byte(input logic [7:0] b, input bit good);
    rx = 1'b0; wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; wait_clks(CPB); end
    model_byte(b, good);
    rx = good; wait_clks(CPB);
    if (!good) begin rx = 1'b1; wait_clks(2 * CPB); end
  endtask

  // Monitor: pops expected frames on receive_end, tallies frame_err.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (receive_end) begin
        re_cyc.push_back(cyc);
        check("excl_err_with_end", W'(frame_err), W'(0));
        if (exp_q.size() == 0) check("spurious_frame", W'(receive_end), W'(0));
        else                   check("frame", data_all, exp_q.pop_front());
      end
      if (frame_err) seen_err++;
    end
  end

  initial begin
    int n0, gap;
    sys_rst = 1'b1;
    rx      = 1'b1;
    wait_clks(3);
    check("rst_data_all", data_all, W'(0));
    check("rst_receive_end", W'(receive_end), W'(0));
    check("rst_frame_err", W'(frame_err), W'(0));
    sys_rst = 1'b0;
    wait_clks(2 * CPB);

    // Incrementing frame, back-to-back bytes.
    for (int i = 0; i < FB; i++) send_byte(8'(i), 1'b1);
    wait_clks(2 * CPB);
    check("inc_byte0", W'(data_all[7:0]), W'(8'h00));
    check("inc_byte19", W'(data_all[159:152]), W'(8'h13));
    check("inc_no_err", W'(seen_err), W'(0));

    // Bad stop bit mid-frame drops the partial frame.
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(255)), 1'b1);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < FB; i++) send_byte(8'h5A, 1'b1);
    wait_clks(2 * CPB);
    check("badstop_err_cnt", W'(seen_err), W'(exp_err));
    check("badstop_frame", data_all, {FB{8'h5A}});

    // Short low glitch on idle line: no byte, no error.
    rx = 1'b0; wait_clks(CPB / 4);
    rx = 1'b1; wait_clks(3 * CPB);
    check("glitch_no_err", W'(seen_err), W'(exp_err));

    // Reset during bit 4 of byte 10.
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(255)), 1'b1);
    rx = 1'b0; wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin rx = 1'($urandom_range(1)); wait_clks(CPB); end
    wait_clks(CPB / 2);
    sys_rst = 1'b1;
    part_q.delete();
    last_exp = '0;
    rx = 1'b1;
    wait_clks(3);
    check("midrst_data_all", data_all, W'(0));
    check("midrst_receive_end", W'(receive_end), W'(0));
    check("midrst_frame_err", W'(frame_err), W'(0));
    sys_rst = 1'b0;
    wait_clks(2 * CPB);
    for (int i = 0; i < FB; i++) send_byte(8'h3C, 1'b1);
    wait_clks(2 * CPB);
    check("midrst_frame", data_all, {FB{8'h3C}});

`ifdef RX_TIMEOUT_EN
    // Stalled partial frame is dropped after the idle timeout.
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(255)), 1'b1);
    wait_clks(40 * CPB);
    part_q.delete();
    exp_err++;
    check("timeout_err_cnt", W'(seen_err), W'(exp_err));
    for (int i = 0; i < FB; i++) send_byte(8'($urandom_range(255)), 1'b1);
    wait_clks(2 * CPB);
    check("timeout_next_frame", data_all, last_exp);
`endif

    // Two frames with no idle between stop and start bits.
    n0 = re_cyc.size();
    for (int i = 0; i < 2 * FB; i++) send_byte(8'($urandom_range(255)), 1'b1);
    wait_clks(2 * CPB);
    check("b2b_count", W'(re_cyc.size() - n0), W'(2));
    if (re_cyc.size() >= n0 + 2) begin
      gap = re_cyc[n0 + 1] - re_cyc[n0];
      check("b2b_spacing", W'(gap >= 200 * CPB - 2 && gap <= 200 * CPB + 2), W'(1));
    end

    // Randomized bytes, occasional bad stop bits and short idle gaps.
    for (int i = 0; i < 90; i++) begin
      send_byte(8'($urandom_range(255)), $urandom_range(15) != 0);
      wait_clks($urandom_range(2) * CPB + $urandom_range(3));
    end
    wait_clks(3 * CPB);

    check("end_exp_drained", W'(exp_q.size()), W'(0));
    check("end_err_cnt", W'(seen_err), W'(exp_err));
    check("end_data_hold", data_all, last_exp);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
